// File: rtl/uart_fact_ctrl_pkg.sv
// Shared types and constants for the UART factorial controller.
package uart_fact_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, MUL, MUL_WAIT, SEND, WAIT_TX} state_t;

  localparam int BYTE_W = 8;

  // Wide enough for any supported RES_W; sliced down at the use site.
  localparam logic [127:0] SAT_ONES = '1;

  // Largest N whose factorial still fits in res_w bits.
  function automatic int max_n_for(input int res_w);
    case (res_w)
      32:      return 12;
      64:      return 20;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/uart_fact_ctrl_seq_mult.sv
// RES_W x 8 shift-add multiplier; done pulses 8 clocks after start.
module seq_mult
  import uart_fact_ctrl_pkg::*;
#(
  parameter int RES_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RES_W-1:0]  a,
  input  logic [BYTE_W-1:0] b,
  output logic              done,
  output logic [RES_W-1:0]  p
);

  logic [RES_W-1:0]  a_sh;
  logic [BYTE_W-1:0] b_sh;
  logic [2:0]        cnt;
  logic              run;

  // First partial product is taken on the start edge so the 8th lands on cycle 7.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      p    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        p    <= b[0] ? a : '0;
        a_sh <= a << 1;
        b_sh <= b >> 1;
        cnt  <= 3'd1;
        run  <= 1'b1;
      end else if (run) begin
        if (b_sh[0]) p <= p + a_sh;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_fact_ctrl.sv
// Receives N, computes N! with a sequential multiplier, returns it MSB-first over uart_tx.
module uart_fact_ctrl
  import uart_fact_ctrl_pkg::*;
#(
  parameter int RES_W = 32,
  parameter int MAX_N = max_n_for(RES_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_dout,
  input  logic              rx_done_tick,
  output logic [BYTE_W-1:0] tx_din,
  output logic              tx_start,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic              ovf,
  output logic              drop
);

  localparam int NBYTES = RES_W / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BYTE_W-1:0] MAX_N8 = BYTE_W'(MAX_N);
  localparam logic [IDX_W-1:0]  LAST   = IDX_W'(NBYTES - 1);

  state_t            state, state_nxt;
  logic [BYTE_W-1:0] n, n_nxt, k, k_nxt;
  logic [RES_W-1:0]  acc, acc_nxt, mult_p;
  logic [IDX_W-1:0]  idx, idx_nxt, byte_sel;
  logic              busy_nxt, ovf_nxt, drop_nxt;
  logic              mult_start, mult_done;
  logic [NBYTES-1:0][BYTE_W-1:0] acc_b;

  seq_mult #(.RES_W(RES_W)) u_mult (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (acc),
    .b     (k),
    .done  (mult_done),
    .p     (mult_p)
  );

  always_comb begin
    state_nxt  = state;
    n_nxt      = n;
    k_nxt      = k;
    acc_nxt    = acc;
    idx_nxt    = idx;
    busy_nxt   = busy;
    ovf_nxt    = ovf;
    drop_nxt   = drop;
    mult_start = 1'b0;
    case (state)
      IDLE: if (rx_done_tick) begin
        n_nxt    = rx_dout;
        busy_nxt = 1'b1;
        ovf_nxt  = 1'b0;
        drop_nxt = 1'b0;
        if (rx_dout > MAX_N8) begin
          acc_nxt   = SAT_ONES[RES_W-1:0];
          ovf_nxt   = 1'b1;
          state_nxt = SEND;
        end else if (rx_dout < 8'd2) begin
          acc_nxt   = RES_W'(1);
          state_nxt = SEND;
        end else begin
          acc_nxt   = RES_W'(1);
          k_nxt     = 8'd2;
          state_nxt = MUL;
        end
      end
      MUL: begin
        mult_start = 1'b1;
        state_nxt  = MUL_WAIT;
      end
      MUL_WAIT: if (mult_done) begin
        acc_nxt   = mult_p;
        k_nxt     = k + 8'd1;
        state_nxt = (k == n) ? SEND : MUL;
      end
      SEND: state_nxt = WAIT_TX;
      WAIT_TX: if (tx_done_tick) begin
        if (idx == LAST) begin
          idx_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (busy && rx_done_tick) drop_nxt = 1'b1;
  end

  // tx_din/tx_start are loaded on entry to SEND so they stay registered outputs.
  assign acc_b    = acc_nxt;
  assign byte_sel = LAST - idx_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      n        <= '0;
      k        <= '0;
      acc      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      drop     <= 1'b0;
      tx_start <= 1'b0;
      tx_din   <= '0;
    end else begin
      state    <= state_nxt;
      n        <= n_nxt;
      k        <= k_nxt;
      acc      <= acc_nxt;
      idx      <= idx_nxt;
      busy     <= busy_nxt;
      ovf      <= ovf_nxt;
      drop     <= drop_nxt;
      tx_start <= (state_nxt == SEND);
      if (state_nxt == SEND) tx_din <= acc_b[byte_sel];
    end
  end

endmodule

// File: tb/tb_uart_fact_ctrl.sv
// Directed bench for uart_fact_ctrl with an expected-byte scoreboard and a modelled uart_tx handshake.
module tb_uart_fact_ctrl;
  import uart_fact_ctrl_pkg::*;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_dout = '0;
  logic       rx_done_tick = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic [7:0] tx_din;
  logic       tx_start, busy, ovf, drop;

  logic [7:0] sb[$];
  int total = 0;
  int fails = 0;

  uart_fact_ctrl #(.RES_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .tx_din       (tx_din),
    .tx_start     (tx_start),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .ovf          (ovf),
    .drop         (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_res(input logic [31:0] r);
    for (int b = NB - 1; b >= 0; b--) sb.push_back(r[b*8 +: 8]);
  endtask

  // Returns in the cycle after the one carrying rx_done_tick (cycle 1).
  task automatic rx_pulse(input logic [7:0] v);
    @(posedge clk); #1;
    rx_dout = v;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic send_req(input logic [7:0] v, input logic [31:0] res);
    push_res(res);
    rx_pulse(v);
  endtask

  // Acts as uart_tx: answers each tx_start with tx_done_tick after dly clocks.
  task automatic serve(input int lat, input int dly, input logic exp_ovf, input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      int w;
      int bad;
      logic [7:0] held;
      w = 0;
      while (tx_start !== 1'b1 && w < 3000) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 3000) begin
        chk("tx_start_timeout", 32'(tx_start), 32'd1);
        return;
      end
      if (b == 0 && lat >= 0) chk("first_tx_start_cycle", 32'(w + 1), 32'(lat));
      chk("sb_depth", 32'(sb.size() > 0), 32'd1);
      chk("tx_din", 32'(tx_din), 32'(sb.pop_front()));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      chk("busy", 32'(busy), 32'd1);
      held = tx_din;
      bad = 0;
      repeat (dly) begin
        @(posedge clk); #1;
        if (tx_start !== 1'b0 || tx_din !== held) bad++;
      end
      chk("hold_stable", 32'(bad), 32'd0);
      tx_done_tick = 1'b1;
      @(posedge clk); #1;
      tx_done_tick = 1'b0;
    end
    if (nbytes == NB) chk("busy_clr", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_din", 32'(tx_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);

    // Stray tx_done_tick in IDLE does nothing.
    tx_done_tick = 1'b1;
    @(posedge clk); #1;
    tx_done_tick = 1'b0;
    @(posedge clk); #1;
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_start", 32'(tx_start), 32'd0);

    send_req(8'd5, 32'd120);         serve(37, 3, 1'b0, NB);
    send_req(8'd0, 32'd1);           serve(1, 2, 1'b0, NB);
    send_req(8'd1, 32'd1);           serve(1, 2, 1'b0, NB);
    send_req(8'd12, 32'h1C8CFC00);   serve(100, 2, 1'b0, NB);
    send_req(8'd13, 32'hFFFFFFFF);   serve(1, 2, 1'b1, NB);
    send_req(8'd255, 32'hFFFFFFFF);  serve(1, 2, 1'b1, NB);

    // Overlapping request during MUL_WAIT is dropped and flagged.
    send_req(8'd7, 32'd5040);
    repeat (4) begin @(posedge clk); #1; end
    rx_pulse(8'd3);
    chk("drop_set", 32'(drop), 32'd1);
    serve(-1, 2, 1'b0, NB);
    chk("drop_sticky", 32'(drop), 32'd1);
    send_req(8'd1, 32'd1);
    chk("drop_cleared", 32'(drop), 32'd0);
    serve(1, 2, 1'b0, NB);

    // Reset between the second tx_start and its tx_done_tick.
    send_req(8'd2, 32'd2);
    serve(10, 2, 1'b0, 1);
    w = 0;
    while (tx_start !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("second_tx_start", 32'(tx_start), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_idle", 32'(dut.state === IDLE), 32'd1);
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    send_req(8'd4, 32'd24);          serve(28, 2, 1'b0, NB);

    // Long uart_tx stall: outputs must hold.
    send_req(8'd3, 32'd6);           serve(19, 1000, 1'b0, NB);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
